// File: rtl/xarb_rr.sv
// rtl/xarb_rr.sv - round-robin, packet-locked N:1 valid/ready arbiter
module xarb_rr #(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_REQ-1:0]         vld_s,
    output logic [N_REQ-1:0]         rdy_s,
    input  logic [N_REQ*D_WIDTH-1:0] data_s,
    input  logic [N_REQ-1:0]         last_s,
    output logic                     vld_m,
    input  logic                     rdy_m,
    output logic [D_WIDTH-1:0]       data_m,
    output logic                     last_m,
    output logic [N_REQ-1:0]         gnt_m
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    off;
    logic [PW-1:0]    sel;
    logic [PW:0]      sum;
    logic [N_REQ-1:0] rot;
    logic             any_vld;
    logic             active;
    logic             xfer;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
        return (x == PW'(N_REQ - 1)) ? '0 : x + PW'(1);
    endfunction

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, then map back.
    always_comb begin
        rot = N_REQ'({vld_s, vld_s} >> ptr);
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = PW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
        win = sum[PW-1:0];
    end

    assign any_vld = |vld_s;
    assign sel     = (state == LOCK) ? owner : win;
    assign active  = rstn & ((state == LOCK) | any_vld);

    always_comb begin
        gnt_m  = '0;
        vld_m  = 1'b0;
        data_m = '0;
        last_m = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == PW'(i)) begin
                gnt_m[i] = active;
                vld_m    = active & vld_s[i];
                data_m   = data_s[i*D_WIDTH +: D_WIDTH];
                last_m   = last_s[i];
            end
        end
    end

    assign rdy_s = gnt_m & {N_REQ{rdy_m}};
    assign xfer  = vld_m & rdy_m;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        if (xfer && last_m) begin
                            ptr <= wrap_inc(win);
                        end else begin
                            state <= LOCK;
                            owner <= win;
                        end
                    end
                end
                LOCK: begin
                    if (xfer && last_m) begin
                        state <= IDLE;
                        ptr   <= wrap_inc(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xarb_rr.sv
// tb/tb_xarb_rr.sv - self-checking bench for xarb_rr against a behavioural model
module tb_xarb_rr;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] vld_s = '0;
    logic [N-1:0] rdy_s;
    logic [N*W-1:0] data_s = '0;
    logic [N-1:0] last_s = '0;
    logic         vld_m;
    logic         rdy_m = 1'b0;
    logic [W-1:0] data_m;
    logic         last_m;
    logic [N-1:0] gnt_m;

    xarb_rr #(.N_REQ(N), .D_WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .vld_s(vld_s), .rdy_s(rdy_s), .data_s(data_s),
        .last_s(last_s), .vld_m(vld_m), .rdy_m(rdy_m), .data_m(data_m),
        .last_m(last_m), .gnt_m(gnt_m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet owner (or none) and the requester with top priority.
    bit m_lock  = 0;
    int m_owner = 0;
    int m_ptr   = 0;

    int           e_sel;
    logic [N-1:0] e_gnt, e_rdy, acc;
    logic         e_vld;
    logic [N-1:0] s_gnt, s_rdy;
    logic         s_vld;
    logic [W-1:0] s_data;
    int           rem [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_eval();
        e_sel = -1;
        if (m_lock) e_sel = m_owner;
        else
            for (int k = 0; k < N; k++)
                if (e_sel < 0 && vld_s[(m_ptr + k) % N]) e_sel = (m_ptr + k) % N;
        e_gnt = (e_sel >= 0) ? N'(1) << e_sel : '0;
        e_vld = (e_sel >= 0) && vld_s[e_sel];
        e_rdy = rdy_m ? e_gnt : '0;
    endfunction

    task automatic step();
        @(negedge clk);
        model_eval();
        s_gnt = gnt_m; s_vld = vld_m; s_data = data_m; s_rdy = rdy_s;
        check("gnt", gnt_m, e_gnt);
        check("vld", vld_m, e_vld);
        check("rdy", rdy_s, e_rdy);
        if (e_vld) begin
            check("data", data_m, data_s[e_sel*W +: W]);
            check("last", last_m, last_s[e_sel]);
        end
        acc = e_rdy & vld_s;
        if (e_sel >= 0) begin
            if (e_vld && rdy_m && last_s[e_sel]) begin
                m_lock = 0;
                m_ptr  = (e_sel + 1) % N;
            end else begin
                m_lock  = 1;
                m_owner = e_sel;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
        vld_s[i] = v;
        last_s[i] = l;
        data_s[i*W +: W] = d;
    endtask

    initial begin
        vld_s = '1;
        rdy_m = 1'b1;
        #12;
        check("rst_vld", vld_m, 1'b0);
        check("rst_rdy", rdy_s, '0);
        check("rst_gnt", gnt_m, '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Rotation: everyone valid with single-beat packets
        last_s = '1;
        for (int i = 0; i < N; i++) data_s[i*W +: W] = W'(16'hC0 + i);
        for (int c = 0; c < 8; c++) begin
            step();
            check("rot_gnt", s_gnt, N'(1) << (c % N));
            check("rot_data", s_data, W'(16'hC0 + (c % N)));
        end

        // Packet lock: requester 2 sends three beats while requester 0 keeps asking
        vld_s = '0;
        set_req(0, 1, 1, 16'h0B00);
        set_req(2, 1, 0, 16'h00A0);
        step();
        check("pl_first", s_gnt, 4'b0001);
        for (int b = 0; b < 3; b++) begin
            set_req(2, 1, b == 2, W'(16'hA0 + b));
            step();
            check("pl_gnt", s_gnt, 4'b0100);
            check("pl_data", s_data, W'(16'hA0 + b));
            check("pl_rdy0", s_rdy[0], 1'b0);
        end
        set_req(2, 0, 0, 16'h0);
        step();
        check("pl_next", s_gnt, 4'b0001);

        // Stall lock: requester 1 stuck on rdy_m=0, requester 0 joins later
        vld_s = '0;
        set_req(1, 1, 1, 16'h5511);
        rdy_m = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_req(0, 1, 1, 16'h0B01);
            step();
            check("st_gnt", s_gnt, 4'b0010);
            check("st_vld", s_vld, 1'b1);
            check("st_data", s_data, 16'h5511);
        end
        rdy_m = 1'b1;
        step();
        check("st_go", s_gnt, 4'b0010);
        set_req(1, 0, 0, 16'h0);
        step();
        check("st_next", s_gnt, 4'b0001);

        // Owner bubble: requester 3 pauses mid-packet while requester 1 waits
        vld_s = '0;
        set_req(3, 1, 0, 16'h3300);
        step();
        check("bb_start", s_gnt, 4'b1000);
        set_req(3, 0, 0, 16'h0);
        set_req(1, 1, 1, 16'h1111);
        for (int c = 0; c < 2; c++) begin
            step();
            check("bb_gnt", s_gnt, 4'b1000);
            check("bb_vld", s_vld, 1'b0);
        end
        set_req(3, 1, 1, 16'h3301);
        step();
        check("bb_last", s_gnt, 4'b1000);
        set_req(3, 0, 0, 16'h0);
        step();
        check("bb_next", s_gnt, 4'b0010);

        // Asynchronous reset in the middle of a packet
        vld_s = '0;
        set_req(2, 1, 0, 16'h2200);
        step();
        set_req(2, 1, 0, 16'h2201);
        #2;
        rstn = 1'b0;
        #1;
        check("mr_vld", vld_m, 1'b0);
        check("mr_gnt", gnt_m, '0);
        check("mr_rdy", rdy_s, '0);
        m_lock = 0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        set_req(0, 1, 1, 16'h0C00);
        set_req(2, 1, 0, 16'h2200);
        step();
        check("mr_restart", s_gnt, 4'b0001);

        // Random traffic: packets of 1..4 beats, upstream holds until accepted
        vld_s = '0;
        acc = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(vld_s[i] && !acc[i])) begin
                    if (rem[i] == 0 && $urandom_range(2) == 0) rem[i] = int'($urandom_range(4, 1));
                    if (rem[i] > 0 && $urandom_range(3) != 0)
                        set_req(i, 1, rem[i] == 1, W'($urandom));
                    else
                        set_req(i, 0, 1'($urandom), W'($urandom));
                end
            end
            rdy_m = ($urandom_range(3) != 0);
            step();
            for (int i = 0; i < N; i++) if (acc[i]) rem[i]--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
